// File: rtl/mem_port_arb.sv
// Memory port controller: arbitrates instruction-fetch and load/store requesters
// onto a single 256x16 RAM with a fixed three-cycle registered access.
module mem_port_arb #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int WDATA_W    = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               f_req,
  input  logic [ADDR_W-1:0]  f_adrs,
  output logic               f_ack,
  output logic [DATA_W-1:0]  f_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_adrs,
  input  logic [WDATA_W-1:0] d_wdata,
  output logic               d_ack,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               ram_rw,
  output logic [ADDR_W-1:0]  ram_adrs,
  output logic [WDATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0]  ram_dout,
  output logic               busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t           state;
  state_t           next_state;
  logic             grant_f;
  logic             grant_d;
  logic             gnt_data;
  logic             gnt_we;
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= next_state;
  end

  // Data wins contention until fetch has been passed over STARVE_MAX times in a row.
  always_comb begin
    next_state = state;
    grant_f    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && f_req) begin
          if (starve_cnt == STARVE_LIM) grant_f = 1'b1;
          else                          grant_d = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (f_req) begin
          grant_f = 1'b1;
        end
        if (grant_f || grant_d) next_state = ACCESS;
      end
      ACCESS:  next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      ram_rw     <= 1'b0;
      ram_adrs   <= '0;
      ram_din    <= '0;
      busy       <= 1'b0;
      gnt_data   <= 1'b0;
      gnt_we     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      busy  <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (grant_d) begin
            ram_adrs <= d_adrs;
            ram_din  <= d_wdata;
            ram_rw   <= d_we;
            gnt_data <= 1'b1;
            gnt_we   <= d_we;
            if (f_req && (starve_cnt != STARVE_LIM)) starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_f) begin
            ram_adrs   <= f_adrs;
            ram_rw     <= 1'b0;
            gnt_data   <= 1'b0;
            gnt_we     <= 1'b0;
            starve_cnt <= '0;
          end
        end
        // The RAM has seen stable pins for a full cycle; a write commits on this edge.
        ACCESS: begin
          ram_rw <= 1'b0;
          if (gnt_data) begin
            d_ack <= 1'b1;
            if (!gnt_we) d_rdata <= ram_dout;
          end else begin
            f_ack   <= 1'b1;
            f_rdata <= ram_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
